// File: rtl/bp_pkg.sv
// Shared branch-predictor types: index/PC widths, the queued prediction record
// and the resolve-unit FSM encoding. Also used by the predictor itself.
package bp_pkg;

   localparam int IDX_W = 5;
   localparam int PC_W  = 64;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic            pred_taken;
      logic [PC_W-1:0] pred_target;
   } pred_entry_t;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } bru_state_t;

   function automatic logic [IDX_W-1:0] pc_index(input logic [PC_W-1:0] pc);
      return pc[IDX_W+1:2];
   endfunction

endpackage

// File: rtl/pred_fifo.sv
// In-order queue of fetch predictions awaiting resolution.
// Ports: i_push/i_din write, i_pop/o_dout head, i_clr drops all, o_full/o_empty.
module pred_fifo
   import bp_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        arst_n,
   input  logic        i_clr,
   input  logic        i_push,
   input  pred_entry_t i_din,
   input  logic        i_pop,
   output pred_entry_t o_dout,
   output logic        o_full,
   output logic        o_empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   pred_entry_t      r_mem [DEPTH];
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [PTR_W:0]   r_cnt;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_cnt == FULL_CNT);
   assign o_empty = (r_cnt == '0);
   assign o_dout  = r_mem[r_rptr];
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;

   always_ff @(posedge clk) begin
      if (w_push && !i_clr)
         r_mem[r_wptr] <= i_din;
   end

   // pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else if (i_clr) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_push)
            r_wptr <= r_wptr + 1'b1;
         if (w_pop)
            r_rptr <= r_rptr + 1'b1;
         if (w_push && !w_pop)
            r_cnt <= r_cnt + 1'b1;
         else if (w_pop && !w_push)
            r_cnt <= r_cnt - 1'b1;
      end
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Matches queued fetch predictions against EX resolutions; drives predictor
// update, mispredict redirect/flush and saturating statistics counters.
module branch_resolve_unit
   import bp_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic             push_valid,
   output logic             push_ready,
   input  logic [PC_W-1:0]  push_pc,
   input  logic             push_pred_taken,
   input  logic [PC_W-1:0]  push_pred_target,
   input  logic             res_valid,
   input  logic             res_taken,
   input  logic [PC_W-1:0]  res_target,
   output logic             upd_en,
   output logic [IDX_W-1:0] upd_addr,
   output logic             upd_taken,
   output logic             redirect_valid,
   output logic [PC_W-1:0]  redirect_pc,
   output logic             res_error,
   output logic [CNT_W-1:0] branch_count,
   output logic [CNT_W-1:0] mispredict_count
);

   bru_state_t  r_state;
   logic        r_live;
   pred_entry_t w_din;
   pred_entry_t w_head;
   logic        w_full;
   logic        w_empty;
   logic        w_act;
   logic        w_res;
   logic        w_err;
   logic        w_mis;
   logic        w_push;

   // r_live keeps push_ready low while reset is held (all outputs 0)
   assign w_act      = r_live && (r_state == ST_RUN);
   assign push_ready = w_act && !w_full;
   assign w_res      = w_act && res_valid && !w_empty;
   assign w_err      = w_act && res_valid && w_empty;
   assign w_mis      = w_res &&
                       ((w_head.pred_taken != res_taken) ||
                        (res_taken && w_head.pred_target != res_target));
   assign w_push     = push_valid && push_ready && !w_mis;

   assign w_din.pc          = push_pc;
   assign w_din.pred_taken  = push_pred_taken;
   assign w_din.pred_target = push_pred_target;

   pred_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .arst_n  (arst_n),
      .i_clr   (w_mis),
      .i_push  (w_push),
      .i_din   (w_din),
      .i_pop   (w_res),
      .o_dout  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_state          <= ST_RUN;
         r_live           <= 1'b0;
         upd_en           <= 1'b0;
         upd_addr         <= '0;
         upd_taken        <= 1'b0;
         redirect_valid   <= 1'b0;
         redirect_pc      <= '0;
         res_error        <= 1'b0;
         branch_count     <= '0;
         mispredict_count <= '0;
      end else begin
         r_live         <= 1'b1;
         upd_en         <= w_res;
         redirect_valid <= w_mis;
         res_error      <= w_err;
         unique case (r_state)
            ST_RUN:   if (w_mis) r_state <= ST_FLUSH;
            ST_FLUSH: r_state <= ST_RUN;
            default:  r_state <= ST_RUN;
         endcase
         if (w_res) begin
            upd_addr  <= pc_index(w_head.pc);
            upd_taken <= res_taken;
            if (branch_count != '1)
               branch_count <= branch_count + 1'b1;
         end
         if (w_mis) begin
            redirect_pc <= res_taken ? res_target : w_head.pc + PC_W'(4);
            if (mispredict_count != '1)
               mispredict_count <= mispredict_count + 1'b1;
         end
      end
   end

endmodule
